// File: rtl/dp_sequencer.sv
// Control sequencer for the 16-bit dual-ALU data path: accepts one instruction
// at a time and plays out its register-file / mux / ALU / output-load controls.
module dp_sequencer #(
  parameter int INSTR_W = 20,
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   instr_count,
  output logic               IE,
  output logic [3:0]         WAA,
  output logic               WEA,
  output logic [3:0]         WAB,
  output logic               WEB,
  output logic [3:0]         RAA,
  output logic               REA,
  output logic [3:0]         RAB,
  output logic               REB,
  output logic               OE,
  output logic [3:0]         S_ALU1,
  output logic [3:0]         S_ALU2,
  output logic [1:0]         dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE, and
  // instr_valid seen in any other state is ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ALU1 = 4'd2;
  localparam logic [3:0] OP_ALU2 = 4'd3;
  localparam logic [3:0] OP_OUT  = 4'd4;

  state_t     state, state_nxt;
  logic [3:0] op_q, fn_q, dst_q, srca_q, srcb_q;
  logic [3:0] op_in;
  logic       accept;

  assign op_in  = instr[19:16];
  assign accept = instr_valid && (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op_in)
            OP_LOAD:                 state_nxt = WR;
            OP_ALU1, OP_ALU2, OP_OUT: state_nxt = RD;
            default:                 state_nxt = DONE;
          endcase
        end
      end
      RD:      state_nxt = WR;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      op_q        <= '0;
      fn_q        <= '0;
      dst_q       <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      err         <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= op_in;
        fn_q   <= instr[15:12];
        dst_q  <= instr[11:8];
        srca_q <= instr[7:4];
        srcb_q <= instr[3:0];
        err    <= (op_in > OP_OUT);
      end
      // Legal ops retire either straight from IDLE (NOP) or out of WR.
      if ((accept && op_in == OP_NOP) || state == WR)
        instr_count <= instr_count + 1'b1;
    end
  end

  // Data-path controls depend only on state and the latched instruction.
  always_comb begin
    IE     = 1'b0;
    WAA    = '0;
    WEA    = 1'b0;
    WAB    = '0;
    WEB    = 1'b0;
    RAA    = '0;
    REA    = 1'b0;
    RAB    = '0;
    REB    = 1'b0;
    OE     = 1'b0;
    S_ALU1 = '0;
    S_ALU2 = '0;
    if (state == RD || state == WR) begin
      case (op_q)
        OP_LOAD: begin
          if (state == WR) begin
            IE  = 1'b1;
            WAB = dst_q;
            WEB = 1'b1;
          end
        end
        OP_ALU1, OP_OUT: begin
          RAA    = srca_q;
          RAB    = srcb_q;
          REA    = 1'b1;
          REB    = 1'b1;
          S_ALU1 = fn_q;
          if (state == WR && op_q == OP_ALU1) begin
            WAA = dst_q;
            WEA = 1'b1;
          end
          if (state == WR && op_q == OP_OUT)
            OE = 1'b1;
        end
        OP_ALU2: begin
          RAB    = srcb_q;
          REB    = 1'b1;
          S_ALU2 = fn_q;
          if (state == WR) begin
            WAB = dst_q;
            WEB = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: directed vector table, a small data-path model,
// randomized instructions against a per-op control model, reset corner cases.
module tb_dp_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [19:0] instr;
  logic        busy, done, err;
  logic [7:0]  instr_count;
  logic        IE, WEA, WEB, REA, REB, OE;
  logic [3:0]  WAA, WAB, RAA, RAB, S_ALU1, S_ALU2;
  logic [1:0]  dbg_state;

  dp_sequencer #(.INSTR_W(20), .CNT_W(8)) dut (
    .CLK(clk), .RST_N(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .busy(busy), .done(done), .err(err), .instr_count(instr_count),
    .IE(IE), .WAA(WAA), .WEA(WEA), .WAB(WAB), .WEB(WEB),
    .RAA(RAA), .REA(REA), .RAB(RAB), .REB(REB), .OE(OE),
    .S_ALU1(S_ALU1), .S_ALU2(S_ALU2), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ie;
    logic [3:0] waa;
    logic       wea;
    logic [3:0] wab;
    logic       web;
    logic [3:0] raa;
    logic       rea;
    logic [3:0] rab;
    logic       reb;
    logic       oe;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       busy;
    logic       done;
    logic       ready;
  } ctrl_t;

  ctrl_t cur;
  assign cur = {IE, WAA, WEA, WAB, WEB, RAA, REA, RAB, REB, OE,
                S_ALU1, S_ALU2, busy, done, instr_ready};

  int total = 0;
  int bad   = 0;
  logic [7:0]  exp_count;
  logic [15:0] data_in;

  // Behavioural data path driven by the sequencer's controls.
  logic [15:0] regs [16];
  logic [15:0] out_q;

  function automatic logic [15:0] alu1(input logic [15:0] a, b, input logic [3:0] fn);
    case (fn)
      4'd0:    return a + b;
      4'd1:    return a;
      4'd2:    return a - b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [15:0] alu2(input logic [15:0] b, input logic [3:0] fn);
    case (fn)
      4'd0:    return b;
      4'd1:    return b + 16'd1;
      default: return ~b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (WEA) regs[WAA] <= alu1(regs[RAA], regs[RAB], S_ALU1);
    if (WEB) regs[WAB] <= IE ? data_in : alu2(regs[RAB], S_ALU2);
    if (OE)  out_q     <= alu1(regs[RAA], regs[RAB], S_ALU1);
  end

  // Reference: cycles from accept to the done cycle, by opcode.
  function automatic int ref_latency(input logic [3:0] op);
    case (op)
      4'd1:             return 2;
      4'd2, 4'd3, 4'd4: return 3;
      default:          return 1;
    endcase
  endfunction

  // Reference: controls expected cyc cycles after accept (0 = idle).
  // The cycle just before done is the write cycle; earlier busy cycles are reads.
  function automatic ctrl_t exp_ctrl(input logic [19:0] ins, input int cyc, input int lat);
    ctrl_t c;
    logic [3:0] op, fn, dst, a, b;
    c = '0;
    {op, fn, dst, a, b} = ins;
    if (cyc == 0) begin
      c.ready = 1'b1;
      return c;
    end
    c.busy = 1'b1;
    if (cyc >= lat) begin
      c.done = 1'b1;
      return c;
    end
    case (op)
      4'd1: begin c.ie = 1'b1; c.wab = dst; c.web = 1'b1; end
      4'd2, 4'd4: begin
        c.raa = a; c.rab = b; c.rea = 1'b1; c.reb = 1'b1; c.s1 = fn;
        if (cyc == lat - 1) begin
          if (op == 4'd2) begin c.waa = dst; c.wea = 1'b1; end
          else c.oe = 1'b1;
        end
      end
      4'd3: begin
        c.rab = b; c.reb = 1'b1; c.s2 = fn;
        if (cyc == lat - 1) begin c.wab = dst; c.web = 1'b1; end
      end
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one instruction and check every cycle through done.
  task automatic run_instr(input logic [19:0] ins, input logic [15:0] din,
                           input bit hold, input int lat_exp, input bit err_exp);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("idle_ctrl", 64'(cur), 64'(exp_ctrl(ins, 0, lat_exp)));
    instr       = ins;
    instr_valid = 1'b1;
    data_in     = din;
    if (!err_exp) exp_count = exp_count + 8'd1;
    @(posedge clk);
    for (int cyc = 1; cyc <= lat_exp; cyc++) begin
      @(negedge clk);
      if (!hold && cyc == 1) begin
        instr_valid = 1'b0;
        instr       = 20'($urandom);
      end
      chk($sformatf("ctrl op%0d cyc%0d", ins[19:16], cyc), 64'(cur),
          64'(exp_ctrl(ins, cyc, lat_exp)));
      if (cyc == lat_exp) begin
        chk("err_at_done", 64'(err), 64'(err_exp));
        chk("count_at_done", 64'(instr_count), 64'(exp_count));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 64'(cur), 64'(exp_ctrl(20'h0, 0, 1)));
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_count", 64'(instr_count), 64'd0);
    rst_n     = 1'b1;
    exp_count = 8'd0;
  endtask

  typedef struct {
    logic [19:0] ins;
    logic [15:0] din;
    int          lat;
    bit          err;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] op;
    logic [19:0] ins;
    bit hold;

    vecs[0] = '{20'h10300, 16'h00A5, 2, 1'b0};  // LOAD R3 <= DataIn
    vecs[1] = '{20'h10100, 16'h0005, 2, 1'b0};  // LOAD R1 <= 5
    vecs[2] = '{20'h10200, 16'h0007, 2, 1'b0};  // LOAD R2 <= 7
    vecs[3] = '{20'h20412, 16'h0000, 3, 1'b0};  // R4 <= R1 + R2
    vecs[4] = '{20'h41040, 16'h0000, 3, 1'b0};  // Out <= pass-A(R4)
    vecs[5] = '{20'h9F123, 16'h0000, 1, 1'b1};  // illegal opcode 9
    vecs[6] = '{20'h0ABCD, 16'h0000, 1, 1'b0};  // NOP clears err
    vecs[7] = '{20'h31601, 16'h0000, 3, 1'b0};  // R6 <= R1 + 1

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    data_in     = '0;
    exp_count   = '0;
    repeat (2) @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++)
      run_instr(vecs[i].ins, vecs[i].din, 1'b0, vecs[i].lat, vecs[i].err);
    @(negedge clk);
    chk("R3", 64'(regs[3]), 64'h00A5);
    chk("R4", 64'(regs[4]), 64'h000C);
    chk("Out", 64'(out_q), 64'h000C);
    chk("R6", 64'(regs[6]), 64'h0006);

    // Randomized instructions, valid sometimes held across the whole sequence.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(5, 15));
      else                           op = 4'($urandom_range(0, 4));
      ins  = {op, 16'($urandom)};
      hold = 1'($urandom_range(0, 1));
      run_instr(ins, 16'($urandom), hold, ref_latency(op), op > 4'd4);
    end
    instr_valid = 1'b0;

    // Reset during the write cycle of an ALU1 op.
    run_instr(20'h10500, 16'h1234, 1'b0, 2, 1'b0);
    @(negedge clk);
    instr       = 20'h20512;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_wr_wea", 64'(WEA), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_wea_drop", 64'(WEA), 64'd0);
    chk("async_state_idle", 64'(dbg_state), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_count = 8'd0;
    chk("R5_kept", 64'(regs[5]), 64'h1234);
    @(negedge clk);
    chk("ready_after_reset", 64'(instr_ready), 64'd1);
    chk("count_after_reset", 64'(instr_count), 64'd0);

    // 256 back-to-back NOPs with valid held high wrap the counter.
    for (int i = 0; i < 256; i++)
      run_instr(20'h00000, 16'h0000, 1'b1, 1, 1'b0);
    instr_valid = 1'b0;
    chk("count_wrap", 64'(instr_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
